// File: rtl/addsub_serial_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM states and
// the slice-counter width helper.
package addsub_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Slice counter width: clog2(n), but never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_serial_digit.sv
// Combinational DIGIT-bit ripple adder slice; also exposes the carry into
// its top bit so the final slice can derive signed overflow.
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic carry;

    always_comb begin
        sum      = '0;
        c_msb_in = 1'b0;
        carry    = cin;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1)
                c_msb_in = carry;
            sum[i] = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract: one DIGIT-bit slice per clock, LSB first, with
// carry/overflow/zero flags and optional signed saturation.
module addsub_serial
    import addsub_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v,
    output logic             z
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
    logic             carry;
    logic [DIGIT-1:0] dsum;
    logic             dcout, dcmsb;
    logic             last, v_raw;
    logic [WIDTH-1:0] sat_val, s_fin;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x        (a_sh[DIGIT-1:0]),
        .y        (b_sh[DIGIT-1:0]),
        .cin      (carry),
        .sum      (dsum),
        .cout     (dcout),
        .c_msb_in (dcmsb)
    );

    // Concatenate-then-shift keeps this valid when N == 1 (no residual bits).
    assign res_nx  = WIDTH'({dsum, res_sh} >> DIGIT);
    assign last    = (cnt == CNT_W'(N - 1));
    assign v_raw   = dcmsb ^ dcout;
    assign sat_val = res_nx[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                     : {1'b1, {(WIDTH-1){1'b0}}};
    assign s_fin   = ((SAT != 0) && v_raw) ? sat_val : res_nx;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nx = ST_RUN;
            ST_RUN:  if (last)      state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            s      <= '0;
            c      <= 1'b0;
            v      <= 1'b0;
            z      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{ctrl}};
                        carry <= ctrl;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    res_sh <= res_nx;
                    carry  <= dcout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        s <= s_fin;
                        c <= dcout;
                        v <= v_raw;
                        z <= (s_fin == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: SAT=0 and SAT=1 instances share stimulus;
// expected results are queued at accept and compared when out_valid rises.
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, ctrl;
    logic [15:0] a, b;
    logic        ir0, ov0, c0, v0, z0;
    logic        ir1, ov1, c1, v1, z1;
    logic [15:0] s0, s1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic [15:0] ss;
        logic        sz;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(16), .DIGIT(4), .SAT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .a(a), .b(b), .ctrl(ctrl), .out_valid(ov0), .out_ready(out_ready),
        .s(s0), .c(c0), .v(v0), .z(z0)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(4), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .a(a), .b(b), .ctrl(ctrl), .out_valid(ov1), .out_ready(out_ready),
        .s(s1), .c(c1), .v(v1), .z(z1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference built from signed/unsigned integer arithmetic, not slices.
    function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb2, input logic tc);
        exp_t e;
        int   r;
        int   ua, ub;
        ua = int'(ta);
        ub = int'(tb2);
        r  = tc ? (int'($signed(ta)) - int'($signed(tb2))) : (int'($signed(ta)) + int'($signed(tb2)));
        e.s  = tc ? 16'(ua - ub) : 16'(ua + ub);
        e.c  = tc ? (ua >= ub) : ((ua + ub) > 65535);
        e.v  = (r > 32767) || (r < -32768);
        e.z  = (e.s == 16'h0000);
        e.ss = (r > 32767) ? 16'h7FFF : (r < -32768) ? 16'h8000 : e.s;
        e.sz = (e.ss == 16'h0000);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ir0 && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_wait", {31'b0, ir0}, 32'd1);
    endtask

    task automatic accept(input logic [15:0] ta, input logic [15:0] tb2, input logic tc);
        a        = ta;
        b        = tb2;
        ctrl     = tc;
        in_valid = 1'b1;
        tick();
        q.push_back(model(ta, tb2, tc));
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        ctrl     = 1'($urandom);
        chk("in_ready_busy", {31'b0, ir0}, 32'd0);
    endtask

    task automatic get_result(input int hold);
        exp_t e;
        int   n = 0;
        while (!ov0 && n < 40) begin
            tick();
            n++;
        end
        chk("latency", n, 32'd4);
        chk("out_valid_sat", {31'b0, ov1}, 32'd1);
        if (q.size() == 0) begin
            chk("scoreboard_empty", q.size(), 32'd1);
        end else begin
            e = q.pop_front();
            chk("s", {16'b0, s0}, {16'b0, e.s});
            chk("c", {31'b0, c0}, {31'b0, e.c});
            chk("v", {31'b0, v0}, {31'b0, e.v});
            chk("z", {31'b0, z0}, {31'b0, e.z});
            chk("sat_s", {16'b0, s1}, {16'b0, e.ss});
            chk("sat_v", {31'b0, v1}, {31'b0, e.v});
            chk("sat_z", {31'b0, z1}, {31'b0, e.sz});
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("hold_valid", {31'b0, ov0}, 32'd1);
                chk("hold_ready", {31'b0, ir0}, 32'd0);
                chk("hold_s", {16'b0, s0}, {16'b0, e.s});
                chk("hold_c", {31'b0, c0}, {31'b0, e.c});
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("valid_drop", {31'b0, ov0}, 32'd0);
            chk("ready_back", {31'b0, ir0}, 32'd1);
            chk("retain_s", {16'b0, s0}, {16'b0, e.s});
        end
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2, input logic tc, input int hold);
        wait_ready();
        accept(ta, tb2, tc);
        get_result(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ctrl      = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) tick();
        chk("rst_valid", {31'b0, ov0}, 32'd0);
        chk("rst_ready", {31'b0, ir0}, 32'd1);
        chk("rst_s", {16'b0, s0}, 32'd0);
        chk("rst_flags", {29'b0, c0, v0, z0}, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(16'h1234, 16'h0FFF, 1'b0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 0);
        run_op(16'h1234, 16'h1234, 1'b1, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 0);

        // Backpressure with a second request held on in_valid throughout.
        wait_ready();
        accept(16'h4321, 16'h1111, 1'b0);
        a        = 16'h1111;
        b        = 16'h2222;
        ctrl     = 1'b0;
        in_valid = 1'b1;
        get_result(5);
        q.push_back(model(16'h1111, 16'h2222, 1'b0));
        tick();
        in_valid = 1'b0;
        chk("second_accept", {31'b0, ir0}, 32'd0);
        get_result(0);

        // Reset during RUN cycle 2.
        wait_ready();
        accept(16'h7FFF, 16'h7FFF, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, ov0}, 32'd0);
        chk("midrst_s", {16'b0, s0}, 32'd0);
        chk("midrst_sat_s", {16'b0, s1}, 32'd0);
        chk("midrst_flags", {29'b0, c0, v0, z0}, 32'd0);
        chk("midrst_ready", {31'b0, ir0}, 32'd1);
        q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        run_op(16'h0001, 16'h0001, 1'b0, 0);

        for (int i = 0; i < 6; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
